// File: rtl/tlb_miss_walker_if.sv
// Bus bundle between the page-table walker, the TLB miss port, the PTE read port
// and the TLB register-write port. The walker uses the master view.
interface tlb_miss_walker_if;
  logic        miss_i;
  logic [31:0] miss_adr_i;
  logic [15:0] miss_asid_i;
  logic [7:0]  miss_id_i;
  logic        missack_o;

  logic        mem_cyc_o;
  logic        mem_stb_o;
  logic [31:0] mem_adr_o;
  logic [63:0] mem_dat_i;
  logic        mem_ack_i;
  logic        mem_err_i;

  logic        tlb_cyc_o;
  logic        tlb_stb_o;
  logic        tlb_we_o;
  logic [7:0]  tlb_sel_o;
  logic [7:0]  tlb_adr_o;
  logic [63:0] tlb_dat_o;
  logic        tlb_ack_i;

  modport master (
    input  miss_i, miss_adr_i, miss_asid_i, miss_id_i,
    output missack_o,
    output mem_cyc_o, mem_stb_o, mem_adr_o,
    input  mem_dat_i, mem_ack_i, mem_err_i,
    output tlb_cyc_o, tlb_stb_o, tlb_we_o, tlb_sel_o, tlb_adr_o, tlb_dat_o,
    input  tlb_ack_i
  );

  modport slave (
    output miss_i, miss_adr_i, miss_asid_i, miss_id_i,
    input  missack_o,
    input  mem_cyc_o, mem_stb_o, mem_adr_o,
    output mem_dat_i, mem_ack_i, mem_err_i,
    input  tlb_cyc_o, tlb_stb_o, tlb_we_o, tlb_sel_o, tlb_adr_o, tlb_dat_o,
    output tlb_ack_i
  );
endinterface

// File: rtl/tlb_miss_walker.sv
// Two-level hardware page-table walker: captures a TLB miss, reads the L1 and L0 PTEs,
// and installs the leaf translation through the TLB register-write bus, or reports a fault.
module tlb_miss_walker #(
  parameter int LOG_PAGESIZE = 13,
  parameter int NWAYS        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ptbr,
  tlb_miss_walker_if.master bus,
  output logic              busy_o,
  output logic              fault_o,
  output logic [1:0]        fault_cause_o,
  output logic [31:0]       fault_adr_o,
  output logic [7:0]        fault_id_o
);
  localparam int PPN_W = 32 - LOG_PAGESIZE;
  localparam int WAY_W = (NWAYS > 1) ? $clog2(NWAYS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RD1, S_RD1_GAP, S_RD0, S_RD0_GAP,
    S_WR_LO, S_WR_LO_GAP, S_WR_HI, S_WR_HI_GAP, S_WR_CTL, S_WR_CTL_GAP,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    C_NONE = 2'd0, C_INVALID = 2'd1, C_BADTYPE = 2'd2, C_BUSERR = 2'd3
  } cause_t;

  state_t           r_state, w_next;
  logic [31:0]      r_adr;
  logic [15:0]      r_asid;
  logic [7:0]       r_id;
  logic [31:0]      r_base;
  logic [63:0]      r_leaf;
  logic [WAY_W-1:0] r_way;
  cause_t           r_fault_cause;
  logic [31:0]      r_fault_adr;
  logic [7:0]       r_fault_id;

  logic             w_capture, w_take_base, w_take_leaf, w_way_inc;
  cause_t           w_cause;
  logic             w_pte_v;
  logic [1:0]       w_pte_typ;
  logic [PPN_W-1:0] w_pte_ppn;
  logic [31:0]      w_l1_adr, w_l0_adr;
  logic [63:0]      w_hi_dat, w_ctl_dat;

  assign w_pte_v   = bus.mem_dat_i[0];
  assign w_pte_typ = bus.mem_dat_i[2:1];
  assign w_pte_ppn = bus.mem_dat_i[32 +: PPN_W];

  assign w_l1_adr  = ptbr + ((r_adr >> (LOG_PAGESIZE + 10)) << 3);
  assign w_l0_adr  = r_base + (((r_adr >> LOG_PAGESIZE) & 32'h0000_03FF) << 3);
  assign w_hi_dat  = (64'(r_adr >> (LOG_PAGESIZE + 9)) << 32) | 64'(r_asid);
  assign w_ctl_dat = 64'(32'h8000_0000 | (32'(r_way) << 16)
                         | ((r_adr >> LOG_PAGESIZE) & 32'h0000_FFFF));

  assign fault_cause_o = r_fault_cause;
  assign fault_adr_o   = r_fault_adr;
  assign fault_id_o    = r_fault_id;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_next        = r_state;
    w_capture     = 1'b0;
    w_take_base   = 1'b0;
    w_take_leaf   = 1'b0;
    w_way_inc     = 1'b0;
    w_cause       = C_NONE;
    bus.missack_o = 1'b0;
    bus.mem_cyc_o = 1'b0;
    bus.mem_stb_o = 1'b0;
    bus.mem_adr_o = '0;
    bus.tlb_cyc_o = 1'b0;
    bus.tlb_stb_o = 1'b0;
    bus.tlb_we_o  = 1'b0;
    bus.tlb_sel_o = '0;
    bus.tlb_adr_o = '0;
    bus.tlb_dat_o = '0;
    busy_o        = (r_state != S_IDLE);
    fault_o       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.miss_i) begin
          w_capture     = 1'b1;
          // Reset holds every output low even while a miss is pending.
          bus.missack_o = !rst;
          w_next        = S_RD1;
        end
      end
      S_RD1: begin
        bus.mem_cyc_o = 1'b1;
        bus.mem_stb_o = 1'b1;
        bus.mem_adr_o = w_l1_adr;
        if (bus.mem_err_i)           w_cause = C_BUSERR;
        else if (bus.mem_ack_i) begin
          if (!w_pte_v)              w_cause = C_INVALID;
          else if (w_pte_typ != 2'd1) w_cause = C_BADTYPE;
          else begin
            w_take_base = 1'b1;
            w_next      = S_RD1_GAP;
          end
        end
      end
      S_RD1_GAP: w_next = S_RD0;
      S_RD0: begin
        bus.mem_cyc_o = 1'b1;
        bus.mem_stb_o = 1'b1;
        bus.mem_adr_o = w_l0_adr;
        if (bus.mem_err_i)           w_cause = C_BUSERR;
        else if (bus.mem_ack_i) begin
          if (!w_pte_v)              w_cause = C_INVALID;
          else if (w_pte_typ != 2'd0) w_cause = C_BADTYPE;
          else begin
            w_take_leaf = 1'b1;
            w_next      = S_RD0_GAP;
          end
        end
      end
      S_RD0_GAP: w_next = S_WR_LO;
      S_WR_LO, S_WR_HI, S_WR_CTL: begin
        bus.tlb_cyc_o = 1'b1;
        bus.tlb_stb_o = 1'b1;
        bus.tlb_we_o  = 1'b1;
        bus.tlb_sel_o = 8'hFF;
        if (r_state == S_WR_LO) begin
          bus.tlb_adr_o = 8'h00;
          bus.tlb_dat_o = r_leaf;
          if (bus.tlb_ack_i) w_next = S_WR_LO_GAP;
        end else if (r_state == S_WR_HI) begin
          bus.tlb_adr_o = 8'h08;
          bus.tlb_dat_o = w_hi_dat;
          if (bus.tlb_ack_i) w_next = S_WR_HI_GAP;
        end else begin
          bus.tlb_adr_o = 8'h20;
          bus.tlb_dat_o = w_ctl_dat;
          if (bus.tlb_ack_i) begin
            w_way_inc = 1'b1;
            w_next    = S_WR_CTL_GAP;
          end
        end
      end
      S_WR_LO_GAP:  w_next = S_WR_HI;
      S_WR_HI_GAP:  w_next = S_WR_CTL;
      S_WR_CTL_GAP: w_next = S_IDLE;
      S_FAULT: begin
        fault_o = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    if (w_cause != C_NONE) w_next = S_FAULT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_adr         <= '0;
      r_asid        <= '0;
      r_id          <= '0;
      r_base        <= '0;
      r_leaf        <= '0;
      r_way         <= '0;
      r_fault_cause <= C_NONE;
      r_fault_adr   <= '0;
      r_fault_id    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      r_state <= w_next;
      if (w_capture) begin
        r_adr  <= bus.miss_adr_i;
        r_asid <= bus.miss_asid_i;
        r_id   <= bus.miss_id_i;
      end
      if (w_take_base) r_base <= {w_pte_ppn, {LOG_PAGESIZE{1'b0}}};
      if (w_take_leaf) r_leaf <= bus.mem_dat_i;
      if (w_way_inc)
        r_way <= (r_way == WAY_W'(NWAYS - 1)) ? '0 : r_way + WAY_W'(1);
      if (w_cause != C_NONE) begin
        r_fault_cause <= w_cause;
        r_fault_adr   <= r_adr;
        r_fault_id    <= r_id;
      end
    end
  end
endmodule

// File: tb/tb_tlb_miss_walker.sv
// Directed, table-driven bench for tlb_miss_walker: walks, faults, stalls and mid-walk reset.
module tb_tlb_miss_walker;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ptbr;
  logic        busy_o, fault_o;
  logic [1:0]  fault_cause_o;
  logic [31:0] fault_adr_o;
  logic [7:0]  fault_id_o;

  tlb_miss_walker_if bus_if ();

  tlb_miss_walker #(.LOG_PAGESIZE(13), .NWAYS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ptbr          (ptbr),
    .bus           (bus_if.master),
    .busy_o        (busy_o),
    .fault_o       (fault_o),
    .fault_cause_o (fault_cause_o),
    .fault_adr_o   (fault_adr_o),
    .fault_id_o    (fault_id_o)
  );

  always #5 clk = ~clk;

  // rsp codes: 0 = ack, 1 = error, 2 = ack and error together
  typedef struct packed {
    logic [31:0] ptbr;
    logic [31:0] vadr;
    logic [15:0] asid;
    logic [7:0]  id;
    logic [63:0] pte1;
    logic [1:0]  rsp1;
    logic [63:0] pte0;
    logic [1:0]  rsp0;
    logic [3:0]  mem_wait;
    logic [3:0]  tlb_wait;
    logic        hold_miss;
    logic        rst_at_hi;
    logic [1:0]  exp_cause;
    logic [1:0]  exp_reads;
    logic [7:0]  exp_cycles;
    logic [31:0] exp_a1;
    logic [31:0] exp_a0;
    logic [63:0] exp_hi;
    logic [63:0] exp_ctl;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  int          cycles, n_missack, n_fault, rd_n, wr_n, mem_wcnt, tlb_wcnt;
  bit          done, stable_ok, tlb_seen;
  logic [31:0] rd_adr [2];
  logic [7:0]  wr_adr [3];
  logic [63:0] wr_dat [3];
  logic [31:0] mem_hold;
  logic [7:0]  tlb_hold_adr;
  logic [63:0] tlb_hold_dat;
  logic [1:0]  f_cause;
  logic [31:0] f_adr;
  logic [7:0]  f_id;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic outs_active();
    return |{bus_if.missack_o, bus_if.mem_cyc_o, bus_if.mem_stb_o, bus_if.mem_adr_o,
             bus_if.tlb_cyc_o, bus_if.tlb_stb_o, bus_if.tlb_we_o, bus_if.tlb_sel_o,
             bus_if.tlb_adr_o, bus_if.tlb_dat_o, busy_o, fault_o, fault_cause_o,
             fault_adr_o, fault_id_o};
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    logic [1:0] rsp;
    @(negedge clk);
    ptbr               = v.ptbr;
    bus_if.miss_adr_i  = v.vadr;
    bus_if.miss_asid_i = v.asid;
    bus_if.miss_id_i   = v.id;
    bus_if.miss_i      = 1'b1;
    cycles = 0; n_missack = 0; n_fault = 0; rd_n = 0; wr_n = 0;
    mem_wcnt = 0; tlb_wcnt = 0; done = 0; stable_ok = 1; tlb_seen = 0;
    rd_adr[0] = '0; rd_adr[1] = '0;
    for (int k = 0; k < 3; k++) begin wr_adr[k] = '0; wr_dat[k] = '0; end
    #1;
    if (bus_if.missack_o) n_missack++;

    while (!done && cycles < 200) begin
      @(negedge clk);
      cycles++;
      bus_if.mem_ack_i = 1'b0;
      bus_if.mem_err_i = 1'b0;
      bus_if.tlb_ack_i = 1'b0;
      if (!busy_o) begin
        done = 1;
      end else begin
        if (bus_if.missack_o) n_missack++;
        if (fault_o) begin
          n_fault++;
          f_cause = fault_cause_o; f_adr = fault_adr_o; f_id = fault_id_o;
          if (v.hold_miss) bus_if.miss_i = 1'b0;
        end
        if (v.rst_at_hi && bus_if.tlb_cyc_o && bus_if.tlb_adr_o == 8'h08) begin
          rst = 1'b1;
          bus_if.miss_i = 1'b0;
          #1;
          check($sformatf("v%0d outputs during mid-walk reset", idx), outs_active(), 1'b0);
          @(negedge clk);
          rst  = 1'b0;
          done = 1;
        end else begin
          if (bus_if.mem_cyc_o) begin
            if (mem_wcnt == 0) mem_hold = bus_if.mem_adr_o;
            else if (bus_if.mem_adr_o !== mem_hold) stable_ok = 0;
            if (!bus_if.mem_stb_o) stable_ok = 0;
            if (mem_wcnt == int'(v.mem_wait)) begin
              if (rd_n < 2) rd_adr[rd_n] = bus_if.mem_adr_o;
              rsp = (rd_n == 0) ? v.rsp1 : v.rsp0;
              bus_if.mem_dat_i = (rd_n == 0) ? v.pte1 : v.pte0;
              bus_if.mem_ack_i = (rsp != 2'd1);
              bus_if.mem_err_i = (rsp != 2'd0);
              rd_n++;
              mem_wcnt = 0;
            end else mem_wcnt++;
          end
          if (bus_if.tlb_cyc_o) begin
            tlb_seen = 1;
            if (tlb_wcnt == 0) begin
              tlb_hold_adr = bus_if.tlb_adr_o;
              tlb_hold_dat = bus_if.tlb_dat_o;
            end else if (bus_if.tlb_adr_o !== tlb_hold_adr || bus_if.tlb_dat_o !== tlb_hold_dat)
              stable_ok = 0;
            if (!bus_if.tlb_stb_o || !bus_if.tlb_we_o || bus_if.tlb_sel_o !== 8'hFF)
              stable_ok = 0;
            if (tlb_wcnt == int'(v.tlb_wait)) begin
              if (wr_n < 3) begin
                wr_adr[wr_n] = bus_if.tlb_adr_o;
                wr_dat[wr_n] = bus_if.tlb_dat_o;
              end
              bus_if.tlb_ack_i = 1'b1;
              wr_n++;
              tlb_wcnt = 0;
              if (v.hold_miss && wr_n == 3) bus_if.miss_i = 1'b0;
            end else tlb_wcnt++;
          end
        end
        if (!v.hold_miss && cycles == 1) bus_if.miss_i = 1'b0;
      end
    end

    check($sformatf("v%0d walk completes", idx), done, 1'b1);
    if (!v.rst_at_hi) begin
      check($sformatf("v%0d missack count", idx), n_missack, 1);
      check($sformatf("v%0d cycles", idx), cycles, v.exp_cycles);
      check($sformatf("v%0d reads", idx), rd_n, v.exp_reads);
      check($sformatf("v%0d L1 adr", idx), rd_adr[0], v.exp_a1);
      if (v.exp_reads == 2'd2) check($sformatf("v%0d L0 adr", idx), rd_adr[1], v.exp_a0);
      check($sformatf("v%0d bus stable", idx), stable_ok, 1'b1);
      check($sformatf("v%0d fault pulses", idx), n_fault, (v.exp_cause != 2'd0) ? 1 : 0);
      if (v.exp_cause != 2'd0) begin
        check($sformatf("v%0d fault cause", idx), f_cause, v.exp_cause);
        check($sformatf("v%0d fault adr", idx), f_adr, v.vadr);
        check($sformatf("v%0d fault id", idx), f_id, v.id);
        check($sformatf("v%0d no tlb cycle", idx), tlb_seen, 1'b0);
      end else begin
        check($sformatf("v%0d writes", idx), wr_n, 3);
        check($sformatf("v%0d wr0 adr", idx), wr_adr[0], 8'h00);
        check($sformatf("v%0d wr1 adr", idx), wr_adr[1], 8'h08);
        check($sformatf("v%0d wr2 adr", idx), wr_adr[2], 8'h20);
        check($sformatf("v%0d entry lo", idx), wr_dat[0], v.pte0);
        check($sformatf("v%0d entry hi", idx), wr_dat[1], v.exp_hi);
        check($sformatf("v%0d update ctl", idx), wr_dat[2], v.exp_ctl);
      end
    end
  endtask

  initial begin
    // ptbr, vadr, asid, id, pte1, rsp1, pte0, rsp0, mem_wait, tlb_wait, hold, rst_at_hi,
    // exp_cause, exp_reads, exp_cycles, exp_a1, exp_a0, exp_hi, exp_ctl
    vecs[0]  = '{32'h1000, 32'hFFF82025, 16'h1234, 8'h05, 64'h00000002_00000003, 2'd0,
                 64'hFFF7FC40_000000F1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd2, 8'd11,
                 32'h1FF8, 32'h5E08, 64'h000003FF_00001234, 64'h8000FFC1};
    vecs[1]  = '{32'h1000, 32'h00000000, 16'h0001, 8'h11, 64'h00000003_00000003, 2'd0,
                 64'h00000001_00000001, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd2, 8'd11,
                 32'h1000, 32'h6000, 64'h00000000_00000001, 64'h80010000};
    vecs[2]  = '{32'h1000, 32'h00802000, 16'hABCD, 8'h22, 64'h00000010_00000003, 2'd0,
                 64'h12345678_00000009, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd2, 8'd11,
                 32'h1008, 32'h00020008, 64'h00000002_0000ABCD, 64'h80020401};
    vecs[3]  = '{32'hFFFFF008, 32'hFFFFFFFF, 16'hFFFF, 8'hFF, 64'h0007FFFF_00000003, 2'd0,
                 64'h00000000_FFFFFFF9, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd2, 8'd11,
                 32'h00000000, 32'hFFFFFFF8, 64'h000003FF_0000FFFF, 64'h8003FFFF};
    vecs[4]  = '{32'h1000, 32'h00004000, 16'h0002, 8'h33, 64'h00000003_00000003, 2'd0,
                 64'h00000005_00000001, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd2, 8'd11,
                 32'h1000, 32'h6010, 64'h00000000_00000002, 64'h80000002};
    vecs[5]  = '{32'h1000, 32'hFFF82025, 16'h1234, 8'h44, 64'h00000002_00000002, 2'd0,
                 64'h0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd1, 2'd1, 8'd3,
                 32'h1FF8, 32'h0, 64'h0, 64'h0};
    vecs[6]  = '{32'h1000, 32'h00000000, 16'h0001, 8'h45, 64'h00000003_00000001, 2'd0,
                 64'h0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd2, 2'd1, 8'd3,
                 32'h1000, 32'h0, 64'h0, 64'h0};
    vecs[7]  = '{32'h1000, 32'h00000000, 16'h0001, 8'h46, 64'h00000003_00000003, 2'd1,
                 64'h0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd3, 2'd1, 8'd3,
                 32'h1000, 32'h0, 64'h0, 64'h0};
    vecs[8]  = '{32'h1000, 32'h00000000, 16'h0001, 8'h47, 64'h00000003_00000003, 2'd2,
                 64'h0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd3, 2'd1, 8'd3,
                 32'h1000, 32'h0, 64'h0, 64'h0};
    vecs[9]  = '{32'h1000, 32'h00000000, 16'h0001, 8'h48, 64'h00000003_00000003, 2'd0,
                 64'h00000001_00000003, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd2, 2'd2, 8'd5,
                 32'h1000, 32'h6000, 64'h0, 64'h0};
    vecs[10] = '{32'h1000, 32'h00000000, 16'h0001, 8'h49, 64'h00000003_00000003, 2'd0,
                 64'h00000001_00000000, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd1, 2'd2, 8'd5,
                 32'h1000, 32'h6000, 64'h0, 64'h0};
    vecs[11] = '{32'h1000, 32'h00000000, 16'h0001, 8'h4A, 64'h00000003_00000003, 2'd0,
                 64'h00000001_00000001, 2'd1, 4'd0, 4'd0, 1'b0, 1'b0, 2'd3, 2'd2, 8'd5,
                 32'h1000, 32'h6000, 64'h0, 64'h0};
    vecs[12] = '{32'h1000, 32'h00000000, 16'h0001, 8'h12, 64'h00000003_00000003, 2'd0,
                 64'h00000001_00000001, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd2, 8'd11,
                 32'h1000, 32'h6000, 64'h00000000_00000001, 64'h80010000};
    vecs[13] = '{32'h1000, 32'hFFF82025, 16'h1234, 8'h05, 64'h00000002_00000003, 2'd0,
                 64'hFFF7FC40_000000F1, 2'd0, 4'd5, 4'd3, 1'b1, 1'b0, 2'd0, 2'd2, 8'd30,
                 32'h1FF8, 32'h5E08, 64'h000003FF_00001234, 64'h8002FFC1};
    vecs[14] = '{32'h1000, 32'hFFF82025, 16'h1234, 8'h05, 64'h00000002_00000003, 2'd0,
                 64'hFFF7FC40_000000F1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b1, 2'd0, 2'd2, 8'd0,
                 32'h1FF8, 32'h5E08, 64'h0, 64'h0};
    vecs[15] = '{32'h1000, 32'hFFF82025, 16'h1234, 8'h05, 64'h00000002_00000003, 2'd0,
                 64'hFFF7FC40_000000F1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd2, 8'd11,
                 32'h1FF8, 32'h5E08, 64'h000003FF_00001234, 64'h8000FFC1};

    rst                = 1'b1;
    ptbr               = 32'h1000;
    bus_if.miss_i      = 1'b1;
    bus_if.miss_adr_i  = 32'hFFF82025;
    bus_if.miss_asid_i = 16'h1234;
    bus_if.miss_id_i   = 8'h05;
    bus_if.mem_dat_i   = '0;
    bus_if.mem_ack_i   = 1'b0;
    bus_if.mem_err_i   = 1'b0;
    bus_if.tlb_ack_i   = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("outputs in reset", outs_active(), 1'b0);
    check("missack in reset with miss pending", bus_if.missack_o, 1'b0);
    bus_if.miss_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
